uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_rx_sync.sv | 21 ++
 rtl/uart_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_rx.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame-length limits and parity encodings.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP1,
        RX_STOP2
    } rx_state_e;

    localparam logic [3:0] UART_LEN_MIN = 4'd5;
    localparam logic [3:0] UART_LEN_MAX = 4'd8;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Any length outside 5..8 falls back to a full byte.
    function automatic logic [3:0] uart_eff_len(input logic [3:0] len);
        if (len >= UART_LEN_MIN && len <= UART_LEN_MAX) begin
            return len;
        end
        return UART_LEN_MAX;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, one serial bit per tx_clk cycle, 5..8 data bits, optional parity, 1 or 2 stops.
// Define UART_RX_SYNC_EN to pass rx through a two-flop synchronizer (+2 cycles latency).
module uart_rx
    import uart_pkg::*;
(
    input  logic       tx_clk,
    input  logic       rstn,
    input  logic       rx,
    input  logic [3:0] length,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       stop,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       rx_parity_err,
    output logic       rx_frame_err,
    output logic       rx_error
);

    logic rx_s;

`ifdef UART_RX_SYNC_EN
    uart_rx_sync u_sync (
        .clk_i  (tx_clk),
        .rstn_i (rstn),
        .d_i    (rx),
        .q_o    (rx_s)
    );
`else
    assign rx_s = rx;
`endif

    rx_state_e  state_q, state_d;
    logic [3:0] len_q, len_d;
    logic       pe_q, pe_d;
    logic       pt_q, pt_d;
    logic       stop_q, stop_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    logic [7:0] data_q, data_d;
    logic       done_q, done_d;
    logic       operr_q, operr_d;
    logic       oferr_q, oferr_d;

    logic       par_exp;
    logic       complete;

    // Bits above the frame length stay zero, so XOR over the whole register is the data parity.
    assign par_exp = (^shift_q) ^ (pt_q == PARITY_ODD);

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        pe_d     = pe_q;
        pt_d     = pt_q;
        stop_d   = stop_q;
        cnt_d    = cnt_q;
        shift_d  = shift_q;
        perr_d   = perr_q;
        ferr_d   = ferr_q;
        data_d   = data_q;
        done_d   = 1'b0;
        operr_d  = operr_q;
        oferr_d  = oferr_q;
        complete = 1'b0;

        case (state_q)
            RX_IDLE: begin
                if (!rx_s) begin
                    len_d   = uart_eff_len(length);
                    pe_d    = parity_en;
                    pt_d    = parity_type;
                    stop_d  = stop;
                    cnt_d   = '0;
                    shift_d = '0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    state_d = RX_DATA;
                end
            end
            RX_DATA: begin
                shift_d[cnt_q] = rx_s;
                cnt_d          = cnt_q + 3'd1;
                if (cnt_q == 3'(len_q - 4'd1)) begin
                    state_d = pe_q ? RX_PARITY : RX_STOP1;
                end
            end
            RX_PARITY: begin
                if (rx_s != par_exp) begin
                    perr_d = 1'b1;
                end
                state_d = RX_STOP1;
            end
            RX_STOP1: begin
                if (!rx_s) begin
                    ferr_d = 1'b1;
                end
                if (stop_q) begin
                    state_d = RX_STOP2;
                end else begin
                    state_d  = RX_IDLE;
                    complete = 1'b1;
                end
            end
            RX_STOP2: begin
                if (!rx_s) begin
                    ferr_d = 1'b1;
                end
                state_d  = RX_IDLE;
                complete = 1'b1;
            end
            default: begin
                state_d = RX_IDLE;
            end
        endcase

        // ferr_d already includes the stop bit sampled this cycle.
        if (complete) begin
            data_d  = shift_q;
            done_d  = 1'b1;
            operr_d = perr_d;
            oferr_d = ferr_d;
        end
    end

    always_ff @(posedge tx_clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RX_IDLE;
            len_q   <= UART_LEN_MAX;
            pe_q    <= 1'b0;
            pt_q    <= 1'b0;
            stop_q  <= 1'b0;
            cnt_q   <= '0;
            shift_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= '0;
            done_q  <= 1'b0;
            operr_q <= 1'b0;
            oferr_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            pe_q    <= pe_d;
            pt_q    <= pt_d;
            stop_q  <= stop_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            operr_q <= operr_d;
            oferr_q <= oferr_d;
        end
    end

    assign rx_data       = data_q;
    assign rx_done       = done_q;
    assign rx_parity_err = operr_q;
    assign rx_frame_err  = oferr_q;
    assign rx_error      = operr_q | oferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frame-level transmitter model plus per-cycle output comparison.
module tb_uart_rx;
    import uart_pkg::*;

`ifdef UART_RX_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif

    logic       tx_clk = 1'b0;
    logic       rstn;
    logic       rx;
    logic [3:0] length;
    logic       parity_en;
    logic       parity_type;
    logic       stop;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       rx_parity_err;
    logic       rx_frame_err;
    logic       rx_error;

    always #5 tx_clk = ~tx_clk;

    uart_rx dut (
        .tx_clk        (tx_clk),
        .rstn          (rstn),
        .rx            (rx),
        .length        (length),
        .parity_en     (parity_en),
        .parity_type   (parity_type),
        .stop          (stop),
        .rx_data       (rx_data),
        .rx_done       (rx_done),
        .rx_parity_err (rx_parity_err),
        .rx_frame_err  (rx_frame_err),
        .rx_error      (rx_error)
    );

    typedef struct {
        int         cyc;
        logic [7:0] d;
        logic       pe;
        logic       fe;
        logic       er;
    } frame_t;

    frame_t expq[$];
    frame_t gotq[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Per-cycle compare against the frame-level model; held values track the last completion.
    initial begin : compare
        logic [7:0] hd;
        logic       hp, hf, exp_done;
        frame_t     e, g;
        hd = '0; hp = 1'b0; hf = 1'b0;
        forever begin
            @(posedge tx_clk);
            cyc++;
            #1;
            exp_done = 1'b0;
            if (!rstn) begin
                expq.delete();
                hd = '0; hp = 1'b0; hf = 1'b0;
            end else begin
                while (expq.size() > 0 && expq[0].cyc < cyc) begin
                    void'(expq.pop_front());
                end
                if (expq.size() > 0 && expq[0].cyc == cyc) begin
                    e = expq.pop_front();
                    exp_done = 1'b1;
                    hd = e.d; hp = e.pe; hf = e.fe;
                end
            end
            chk("rx_done",       32'(rx_done),       32'(exp_done));
            chk("rx_data",       32'(rx_data),       32'(hd));
            chk("rx_parity_err", 32'(rx_parity_err), 32'(hp));
            chk("rx_frame_err",  32'(rx_frame_err),  32'(hf));
            chk("rx_error",      32'(rx_error),      32'(hp | hf));
            if (rx_done === 1'b1) begin
                g.cyc = cyc; g.d = rx_data; g.pe = rx_parity_err;
                g.fe = rx_frame_err; g.er = rx_error;
                gotq.push_back(g);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge tx_clk);
            rx = 1'b1;
        end
    endtask

    task automatic send_frame(input logic [7:0] data, input logic [3:0] len_in,
                              input logic pe, input logic pt, input logic st,
                              input logic flip_par, input logic [1:0] stopv,
                              output int s);
        int         L;
        logic       par;
        logic [7:0] mask;
        frame_t     e;
        L = (len_in >= 4'd5 && len_in <= 4'd8) ? int'(len_in) : 8;
        mask = 8'hFF >> (8 - L);
        par = 1'b0;
        for (int i = 0; i < L; i++) par ^= data[i];
        if (pt) par = ~par;
        par ^= flip_par;

        @(negedge tx_clk);
        rx = 1'b0;
        length = len_in; parity_en = pe; parity_type = pt; stop = st;
        s = cyc;
        e.cyc = s + 1 + L + int'(pe) + (st ? 2 : 1) + SYNC_LAT;
        e.d   = data & mask;
        e.pe  = pe & flip_par;
        e.fe  = !stopv[0] || (st && !stopv[1]);
        e.er  = e.pe | e.fe;
        expq.push_back(e);

        for (int i = 0; i < L; i++) begin
            @(negedge tx_clk);
            rx = data[i];
            if (i == L - 1) begin
                // Format changes late in the frame must not disturb it.
                length = 4'($urandom); parity_en = 1'($urandom);
                parity_type = 1'($urandom); stop = 1'($urandom);
            end
        end
        if (pe) begin
            @(negedge tx_clk);
            rx = par;
        end
        @(negedge tx_clk);
        rx = stopv[0];
        if (st) begin
            @(negedge tx_clk);
            rx = stopv[1];
        end
    endtask

    task automatic check_got(input string name, input int idx, input int s, input int lat,
                             input logic [7:0] d, input logic pe, input logic fe);
        n_checks++;
        if (gotq.size() <= idx) begin
            n_fail++;
            $display("FAIL %s: got %0d completions, expected more than %0d", name, gotq.size(), idx);
        end else begin
            n_checks--;
            chk({name, "_latency"}, 32'(gotq[idx].cyc - s), 32'(lat + SYNC_LAT));
            chk({name, "_data"},    32'(gotq[idx].d),  32'(d));
            chk({name, "_perr"},    32'(gotq[idx].pe), 32'(pe));
            chk({name, "_ferr"},    32'(gotq[idx].fe), 32'(fe));
            chk({name, "_err"},     32'(gotq[idx].er), 32'(pe | fe));
        end
    endtask

    initial begin : stimulus
        int s, s2, nframes;
        rstn = 1'b0; rx = 1'b1; length = 4'd8;
        parity_en = 1'b0; parity_type = 1'b0; stop = 1'b0;
        repeat (3) @(negedge tx_clk);
        chk("reset_data",  32'(rx_data), 32'h0);
        chk("reset_done",  32'(rx_done), 32'h0);
        chk("reset_error", 32'({rx_parity_err, rx_frame_err, rx_error}), 32'h0);
        @(negedge tx_clk);
        rstn = 1'b1;
        idle(3);

        // 8N1 0xA5
        gotq.delete();
        send_frame(8'hA5, 4'd8, 1'b0, PARITY_EVEN, 1'b0, 1'b0, 2'b11, s);
        idle(6);
        chk("t1_count", 32'(gotq.size()), 32'd1);
        check_got("t1", 0, s, 10, 8'hA5, 1'b0, 1'b0);

        // 5 bits even parity, wrong parity bit
        gotq.delete();
        send_frame(8'b10110, 4'd5, 1'b1, PARITY_EVEN, 1'b0, 1'b1, 2'b11, s);
        idle(6);
        check_got("t2", 0, s, 8, 8'h16, 1'b1, 1'b0);

        // 7 bits odd parity, 2 stops, second stop 0
        gotq.delete();
        send_frame(8'h7F, 4'd7, 1'b1, PARITY_ODD, 1'b1, 1'b0, 2'b01, s);
        idle(6);
        check_got("t3", 0, s, 11, 8'h7F, 1'b0, 1'b1);

        // 8 bits, parity, 2 stops: latency 12
        gotq.delete();
        send_frame(8'h81, 4'd8, 1'b1, PARITY_EVEN, 1'b1, 1'b0, 2'b11, s);
        idle(6);
        check_got("t4", 0, s, 12, 8'h81, 1'b0, 1'b0);

        // back-to-back 8N1 frames
        gotq.delete();
        send_frame(8'h3C, 4'd8, 1'b0, PARITY_EVEN, 1'b0, 1'b0, 2'b11, s);
        send_frame(8'hC3, 4'd8, 1'b0, PARITY_EVEN, 1'b0, 1'b0, 2'b11, s2);
        idle(6);
        chk("t5_count", 32'(gotq.size()), 32'd2);
        check_got("t5a", 0, s, 10, 8'h3C, 1'b0, 1'b0);
        check_got("t5b", 1, s, 20, 8'hC3, 1'b0, 1'b0);

        // reset at data bit 4, then 0x55
        gotq.delete();
        @(negedge tx_clk); rx = 1'b0;
        length = 4'd8; parity_en = 1'b0; stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge tx_clk); rx = 1'($urandom);
        end
        @(negedge tx_clk); rstn = 1'b0; rx = 1'b1;
        repeat (3) @(negedge tx_clk);
        rstn = 1'b1;
        idle(2);
        send_frame(8'h55, 4'd8, 1'b0, PARITY_EVEN, 1'b0, 1'b0, 2'b11, s);
        idle(6);
        chk("t6_count", 32'(gotq.size()), 32'd1);
        check_got("t6", 0, s, 10, 8'h55, 1'b0, 1'b0);

        // out-of-range lengths behave as 8
        gotq.delete();
        send_frame(8'hC9, 4'd12, 1'b0, PARITY_EVEN, 1'b0, 1'b0, 2'b11, s);
        idle(1);
        send_frame(8'h96, 4'd3, 1'b1, PARITY_ODD, 1'b0, 1'b0, 2'b11, s2);
        idle(6);
        check_got("t7a", 0, s, 10, 8'hC9, 1'b0, 1'b0);
        check_got("t7b", 1, s2, 11, 8'h96, 1'b0, 1'b0);

        // loopback sweep: lengths x parity off/even/odd x stops, random data
        gotq.delete();
        nframes = 0;
        for (int rep = 0; rep < 2; rep++) begin
            for (int len = 5; len <= 8; len++) begin
                for (int pm = 0; pm < 3; pm++) begin
                    for (int st = 0; st < 2; st++) begin
                        send_frame(8'($urandom), 4'(len), pm != 0, pm == 2, st != 0,
                                   1'b0, 2'b11, s);
                        nframes++;
                        idle(int'($urandom_range(0, 2)));
                    end
                end
            end
        end
        idle(20);
        chk("loop_count", 32'(gotq.size()), 32'(nframes));
        for (int i = 0; i < gotq.size(); i++) begin
            chk("loop_error", 32'(gotq[i].er), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
